// File: rtl/crc_code_pkg.sv
// rtl/crc_code_pkg.sv - shared constants, FSM states and CRC-4 helpers for the CRC code read path
package crc_code_pkg;

  localparam int DATA_W = 8;
  localparam int CRC_W  = 4;
  localparam int ADDR_W = 4;
  localparam int WORD_W = DATA_W + CRC_W;
  localparam logic [CRC_W-1:0] CRC_POLY = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_FETCH,
    ST_CAPTURE,
    ST_CHECK,
    ST_REPORT
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] pos;
  } fix_t;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r,
                                                input logic             d,
                                                input logic [CRC_W-1:0] poly);
    logic fb;
    fb = r[CRC_W-1] ^ d;
    return {r[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction

  // Syndrome of a single flipped bit i is x^i mod g(x); weights 1001/1101/1111 never occur.
  function automatic fix_t syndrome_to_pos(input logic [CRC_W-1:0] s);
    fix_t f;
    f.valid = 1'b1;
    case (s)
      4'b0001: f.pos = 4'd0;
      4'b0010: f.pos = 4'd1;
      4'b0100: f.pos = 4'd2;
      4'b1000: f.pos = 4'd3;
      4'b0011: f.pos = 4'd4;
      4'b0110: f.pos = 4'd5;
      4'b1100: f.pos = 4'd6;
      4'b1011: f.pos = 4'd7;
      4'b0101: f.pos = 4'd8;
      4'b1010: f.pos = 4'd9;
      4'b0111: f.pos = 4'd10;
      4'b1110: f.pos = 4'd11;
      default: begin
        f.valid = 1'b0;
        f.pos   = 4'd0;
      end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/crc_code_serial_lfsr.sv
// rtl/crc_code_serial_lfsr.sv - bit-serial CRC-4 LFSR shared by the read checker and write encoder
module crc_code_serial_lfsr
  import crc_code_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_out
);

  logic [CRC_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_q <= '0;
    end else if (shift_en) begin
      r_q <= crc_step(r_q, bit_in, POLY);
    end
  end

  assign crc_out = r_q;

endmodule

// File: rtl/crc_code_read_checker.sv
// rtl/crc_code_read_checker.sv - serial-address read of a CRC-4 codeword with serial recheck.
// Defining CRC_CHECK_CORRECT_EN adds single-bit correction and the corrected output.
module crc_code_read_checker
  import crc_code_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC_POLY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              addr_in,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [WORD_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              crc_error,
`ifdef CRC_CHECK_CORRECT_EN
  output logic              corrected,
`endif
  output logic              read_busy
);

  state_e            state_q;
  logic [ADDR_W-2:0] addr_sr_q;
  logic [2:0]        cnt_q;
  logic [WORD_W-1:0] word_q;
  logic [ADDR_W-1:0] mem_read_addr_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              crc_error_q;
  logic              read_busy_q;

  logic              lfsr_clear;
  logic              lfsr_shift;
  logic              lfsr_bit;
  logic [CRC_W-1:0]  lfsr_crc;
  logic [DATA_W-1:0] data_bits;
  logic [CRC_W-1:0]  crc_final_d;
  logic [CRC_W-1:0]  syndrome_d;
  logic [DATA_W-1:0] rep_data_d;
  logic              rep_err_d;

  assign data_bits  = word_q[WORD_W-1:CRC_W];
  assign lfsr_clear = (state_q == ST_CAPTURE);
  assign lfsr_shift = (state_q == ST_CHECK);
  assign lfsr_bit   = data_bits[3'd7 - cnt_q];

  crc_code_serial_lfsr #(
    .POLY(POLY)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .clear   (lfsr_clear),
    .shift_en(lfsr_shift),
    .bit_in  (lfsr_bit),
    .crc_out (lfsr_crc)
  );

  // The report registers load on the last CHECK edge, so the 8th bit is folded in here.
  assign crc_final_d = crc_step(lfsr_crc, lfsr_bit, POLY);
  assign syndrome_d  = crc_final_d ^ word_q[CRC_W-1:0];

`ifdef CRC_CHECK_CORRECT_EN
  fix_t fix_d;
  logic rep_corr_d;
  logic corrected_q;

  always_comb begin
    fix_d      = syndrome_to_pos(syndrome_d);
    rep_data_d = data_bits;
    rep_err_d  = (syndrome_d != '0);
    rep_corr_d = 1'b0;
    if ((syndrome_d != '0) && fix_d.valid) begin
      rep_err_d  = 1'b0;
      rep_corr_d = 1'b1;
      if (fix_d.pos >= 4'd4) begin
        rep_data_d = data_bits ^ (DATA_W'(1) << (fix_d.pos - 4'd4));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      corrected_q <= 1'b0;
    end else if (state_q == ST_CHECK && cnt_q == 3'd7) begin
      corrected_q <= rep_corr_d;
    end
  end

  assign corrected = corrected_q;
`else
  always_comb begin
    rep_data_d = data_bits;
    rep_err_d  = (syndrome_d != '0);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_sr_q       <= '0;
      cnt_q           <= '0;
      word_q          <= '0;
      mem_read_addr_q <= '0;
      data_out_q      <= '0;
      data_valid_q    <= 1'b0;
      crc_error_q     <= 1'b0;
      read_busy_q     <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (read) begin
            state_q     <= ST_ADDR;
            cnt_q       <= '0;
            read_busy_q <= 1'b1;
          end
        end
        ST_ADDR: begin
          addr_sr_q <= {addr_sr_q[ADDR_W-3:0], addr_in};
          cnt_q     <= cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            state_q         <= ST_FETCH;
            mem_read_addr_q <= {addr_sr_q, addr_in};
          end
        end
        ST_FETCH: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          word_q  <= mem_read_data;
          cnt_q   <= '0;
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q      <= ST_REPORT;
            data_out_q   <= rep_data_d;
            crc_error_q  <= rep_err_d;
            data_valid_q <= 1'b1;
          end
        end
        ST_REPORT: begin
          state_q     <= ST_IDLE;
          read_busy_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          read_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read_addr = mem_read_addr_q;
  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign crc_error     = crc_error_q;
  assign read_busy     = read_busy_q;

endmodule

// File: tb/tb_crc_code_read_checker.sv
// tb/tb_crc_code_read_checker.sv - directed self-checking bench for crc_code_read_checker
module tb_crc_code_read_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic        addr_in = 1'b0;
  logic [3:0]  mem_read_addr;
  logic [11:0] mem_read_data = 12'h000;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        crc_error;
  logic        read_busy;
`ifdef CRC_CHECK_CORRECT_EN
  logic        corrected;
  localparam bit CORR_BUILD = 1'b1;
`else
  localparam bit CORR_BUILD = 1'b0;
`endif

  logic [11:0] mem [16];
  int          n_checks = 0;
  int          n_fail = 0;
  int          pulses = 0;
  int          pulses_before;

  crc_code_read_checker dut (
    .clk          (clk),
    .rst          (rst),
    .read         (read),
    .addr_in      (addr_in),
    .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .crc_error    (crc_error),
`ifdef CRC_CHECK_CORRECT_EN
    .corrected    (corrected),
`endif
    .read_busy    (read_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_read_data <= mem[mem_read_addr];

  always @(posedge clk) if (data_valid === 1'b1) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr"}, 16'(mem_read_addr), 16'h0);
    check({tag, "_data"}, 16'(data_out), 16'h0);
    check({tag, "_dv"}, 16'(data_valid), 16'h0);
    check({tag, "_err"}, 16'(crc_error), 16'h0);
    check({tag, "_busy"}, 16'(read_busy), 16'h0);
`ifdef CRC_CHECK_CORRECT_EN
    check({tag, "_corr"}, 16'(corrected), 16'h0);
`endif
  endtask

  // Cycle 0 is the IDLE cycle with read high; each negedge is mid-cycle.
  task automatic run_read(input string tag, input logic [3:0] a, input logic [7:0] ed,
                          input logic ee, input logic ec, input int repulse, input int abort_at);
    @(negedge clk);
    check({tag, "_idle_busy"}, 16'(read_busy), 16'h0);
    read = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      read = (c == repulse);
      addr_in = (c <= 4) ? a[4-c] : 1'b0;
      if (abort_at != 0 && c == abort_at + 1) begin
        rst = 1'b0;
        check_outputs_zero({tag, "_abort"});
        return;
      end
      if (abort_at != 0 && c == abort_at) rst = 1'b1;
      check({tag, "_busy"}, 16'(read_busy), 16'h1);
      if (c == 5) check({tag, "_maddr"}, 16'(mem_read_addr), 16'(a));
      if (c < 15) begin
        check({tag, "_dv_early"}, 16'(data_valid), 16'h0);
      end else begin
        check({tag, "_dv"}, 16'(data_valid), 16'h1);
        check({tag, "_data"}, 16'(data_out), 16'(ed));
        check({tag, "_err"}, 16'(crc_error), 16'(ee));
`ifdef CRC_CHECK_CORRECT_EN
        check({tag, "_corr"}, 16'(corrected), 16'(ec));
`endif
      end
    end
    read = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 12'h000;
    mem[4'h6] = 12'hA5B;
    mem[4'hF] = 12'hFF4;
    mem[4'h0] = 12'h000;
    mem[4'h1] = 12'h85B;
    mem[4'h2] = 12'h24B;
    mem[4'h3] = 12'hA5A;
    mem[4'hA] = 12'hFF4;

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    run_read("t1", 4'h6, 8'hA5, 1'b0, 1'b0, 0, 0);

    run_read("t2a", 4'hF, 8'hFF, 1'b0, 1'b0, 0, 0);
    run_read("t2b", 4'h0, 8'h00, 1'b0, 1'b0, 0, 0);

    if (CORR_BUILD) run_read("t3", 4'h1, 8'hA5, 1'b0, 1'b1, 0, 0);
    else            run_read("t3", 4'h1, 8'h85, 1'b1, 1'b0, 0, 0);

    run_read("t4", 4'h2, 8'h24, 1'b1, 1'b0, 0, 0);

    @(negedge clk);
    pulses_before = pulses;
    run_read("t5", 4'h6, 8'hA5, 1'b0, 1'b0, 9, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("t5_ignored_busy", 16'(read_busy), 16'h0);
      check("t5_hold_data", 16'(data_out), 16'hA5);
    end
    check("t5_pulse_count", 16'(pulses - pulses_before), 16'h1);

    pulses_before = pulses;
    run_read("t5_rst", 4'hA, 8'hFF, 1'b0, 1'b0, 0, 9);
    repeat (20) @(negedge clk);
    check("t5_rst_no_pulse", 16'(pulses - pulses_before), 16'h0);
    check("t5_rst_idle_busy", 16'(read_busy), 16'h0);
    run_read("t5_after", 4'h6, 8'hA5, 1'b0, 1'b0, 0, 0);

    if (CORR_BUILD) run_read("t6", 4'h3, 8'hA5, 1'b0, 1'b1, 0, 0);
    else            run_read("t6", 4'h3, 8'hA5, 1'b1, 1'b0, 0, 0);

    @(negedge clk);
    check("final_busy", 16'(read_busy), 16'h0);
    check("final_dv", 16'(data_valid), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_code_read_checker.md
Name: crc_code_read_checker

Overview:
Read-path stage of the CRC-protected memory; it sits directly downstream of the 12-bit CRC word memory. It accepts a read command with a serially shifted 4-bit address and fetches the stored codeword. It recomputes the CRC-4 over the 8 data bits with a serial LFSR, compares it against the stored check bits, and presents the data byte with an error flag and a busy signal. It also drives the memory read address, so it is the consumer of the memory's read_data port.

Parameters:
DATA_W, 8, data bits per codeword (codeword[11:4])
CRC_W, 4, check bits per codeword (codeword[3:0])
ADDR_W, 4, memory address width, shifted in serially
POLY, 4'b0011, CRC polynomial x^4+x+1, implicit x^4 term
The syndrome table (optional feature) is valid only for the defaults.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
read  input  1  read request; accepted only in IDLE
addr_in  input  1  serial address bit, MSB first, sampled in ADDR
mem_read_addr  output  ADDR_W  address to memory read port
mem_read_data  input  DATA_W+CRC_W  registered memory read data, 1-cycle latency
data_out  output  DATA_W  checked data byte
data_valid  output  1  one-cycle pulse: data_out/crc_error valid
crc_error  output  1  stored CRC mismatch (uncorrectable when correction compiled in)
read_busy  output  1  high while a read is in progress

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - mem_read_addr=0, data_out=0, data_valid=0, crc_error=0, read_busy=0.
  - The LFSR, shift counter and word register are cleared.
  - Reset asserted mid-operation aborts the read at the next edge. No data_valid pulse is produced for the aborted read.
- States: IDLE, ADDR, FETCH, CAPTURE, CHECK, REPORT.
- IDLE:
  - If read=1, go to ADDR.
  - read asserted in any other state is ignored (not queued).
- ADDR:
  - Lasts 4 cycles.
  - Each cycle: addr_sr <= {addr_sr[2:0], addr_in}.
  - After the 4th bit, go to FETCH.
- FETCH:
  - Lasts 1 cycle.
  - mem_read_addr = assembled address. The memory samples it at the end of this cycle.
  - mem_read_addr holds its value until the next FETCH.
- CAPTURE:
  - Lasts 1 cycle.
  - word_reg <= mem_read_data.
  - LFSR cleared to 0.
- CHECK:
  - Lasts 8 cycles.
  - Data bits word_reg[11] down to word_reg[4] are fed MSB first.
  - Each cycle: fb = r[3]^d; r <= {r[2:0],1'b0} ^ (fb ? POLY : 0).
  - A 3-bit counter terminates the state after the 8th bit.
- REPORT:
  - Lasts 1 cycle.
  - data_out <= word_reg[11:4].
  - crc_error <= (r != word_reg[3:0]).
  - data_valid=1 for this cycle only.
  - Next state is IDLE.
- Timing, with read accepted at cycle 0:
  - ADDR: cycles 1-4.
  - FETCH: cycle 5.
  - CAPTURE: cycle 6.
  - CHECK: cycles 7-14.
  - REPORT: cycle 15.
  - read_busy is high in cycles 1-15.
  - A new read can be accepted in the first IDLE cycle after REPORT.
- data_out and crc_error hold their values between REPORT pulses.
- syndrome = r ^ word_reg[3:0]; it is zero if and only if the stored codeword is valid.

Optional Feature:
CRC_CHECK_CORRECT_EN
- Defined:
  - Adds output corrected (1 bit, reset 0, updated in REPORT).
  - The syndrome is mapped to a codeword bit position:
    - 0001/0010/0100/1000 map to bits 0-3 (check bit flipped; data unchanged; corrected=1).
    - 0011/0110/1100/1011/0101/1010/0111/1110 map to bits 4-11 (that data bit is inverted in data_out; corrected=1).
    - 1001, 1101 and 1111 are uncorrectable: crc_error=1, corrected=0, raw data output.
  - With correction, crc_error=1 only for uncorrectable syndromes.
  - Latency is unchanged; the table is combinational inside REPORT.
- Undefined: no corrected port; detection only.

Decomposition:
- Package crc_code_pkg:
  - Constants DATA_W, CRC_W, ADDR_W, WORD_W=12, CRC_POLY=4'b0011.
  - FSM state enum.
  - Syndrome-to-position function.
- One sub-module: crc_code_serial_lfsr. Ports: clk, rst, clear, shift_en, bit_in, crc_out[3:0]. It is shared with the write-side encoder.

Test Plan:
1. Memory word 0xA5B at address 0x6; read pulse with addr bits 0,1,1,0 -> mem_read_addr=0x6 in cycle 5; data_valid in cycle 15; data_out=0xA5; crc_error=0.
2. Word 0xFF4 at address 0xF, then word 0x000 at address 0x0, in back-to-back reads -> 0xFF/err 0, then 0x00/err 0. Second read is accepted the cycle after REPORT; read_busy low for exactly that cycle.
3. Word 0x85B (bit 9 flipped from 0xA5B):
   - Without macro: data_out=0x85, crc_error=1.
   - With CRC_CHECK_CORRECT_EN: data_out=0xA5, corrected=1, crc_error=0.
4. Word 0x24B (bits 11 and 4 flipped from 0xA5B) -> crc_error=1 in both builds; corrected=0 with the macro defined; data_out=0x24.
5. read re-pulsed during CHECK -> ignored; exactly one data_valid pulse. Then rst asserted in cycle 9 of a new read -> all outputs 0 next cycle; no data_valid pulse; next read completes normally.
6. Word 0xA5A (check bit 0 flipped):
   - Without macro: crc_error=1.
   - With macro: data_out=0xA5, corrected=1, crc_error=0.
